dep_wakeup_age_matrix: RTL and testbench
========================================

// Module: dep_wakeup_age_matrix
// PURPOSE
//  Multi-port dependency (wakeup) matrix with an age matrix for one scheduler bank.
//  - Each row tracks one reservation-station entry's pending producers (columns).
//  - Rows are woken up by broadcast column clears.
//  - Each cycle, the oldest ready row is offered for issue; it is freed on acknowledge.
//  - Sits between rename/dispatch (writes) and the FU select/issue stage.
// PARAMETERS
//  NUM_ROWS   8  entries in the bank
//  NUM_COLS   8  dependency columns (producer tags)
//  NUM_WR     2  dispatch write ports per cycle; port 0 is older than port 1, and so on
//  NUM_CLR    2  wakeup/clear broadcast ports per cycle
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 reset
//  wr_en          in   NUM_WR            per-port write enable
//  wr_row         in   NUM_WR*RIW        row index per port; RIW = $clog2(NUM_ROWS)
//  wr_deps        in   NUM_WR*NUM_COLS   dependency bits per port
//  clr_en         in   NUM_CLR           per-port clear enable
//  clr_cols       in   NUM_CLR*NUM_COLS  columns to clear per port
//  flush_en       in   1                 squash rows in flush_mask
//  flush_mask     in   NUM_ROWS          rows to squash
//  issue_valid    out  1                 some valid row has zero dependencies
//  issue_row      out  RIW               oldest ready row
//  issue_ack      in   1                 consumer took issue_row; free it at the next clk edge
//  ready_vector   out  NUM_ROWS          valid && no pending deps (combinational from state)
//  changed_vector out  NUM_ROWS          registered 1-cycle pulse: row lost >=1 dep bit last cycle
//  occupancy      out  $clog2(NUM_ROWS+1)  count of valid rows (registered)
//  full           out  1                 occupancy == NUM_ROWS
// BEHAVIOUR
//  - Reset values: all matrix bits, row_valid, changed_vector and occupancy = 0.
//    This gives issue_valid=0, issue_row=0, full=0.
//  - dep[r][c]=1 means row r waits on column c.
//    Effective clear mask CM = OR over ports k of (clr_en[k] ? clr_cols[k] : 0).
//  - Clear: for each valid row r, dep[r] <= dep[r] & ~CM.
//    changed_vector[r] <= |(dep[r] & CM) && row r stays valid next cycle.
//  - Write: on port p, for row w: dep[w] <= wr_deps[p] & ~CM (same-cycle wakeup bypass; no lost wakeup).
//    Also row_valid[w] <= 1. changed_vector[w] <= 0.
//  - Age: age[i][j]=1 means i is older than j. A written row becomes younger than:
//    - all rows valid before this cycle;
//    - lower-numbered write ports in the same cycle.
//    Set age[j][w]=1 and age[w][j]=0 for those j.
//  - Select (combinational): issue_row = the ready r such that no other ready j has age[j][r].
//    issue_valid = |ready_vector. issue_row = 0 when none is ready.
//  - Free: issue_ack && issue_valid clears row_valid[issue_row] and dep[issue_row].
//    issue_ack while !issue_valid is ignored.
//  - Flush: rows in flush_mask are invalidated and zeroed. changed_vector for them is 0.
//  - Priority per row, same cycle: write > flush > free > clear.
//    Write to the row being freed or flushed is legal; the new entry survives.
//  - Illegal, caught by assertion only:
//    - writing a row already valid and not being freed or flushed this cycle;
//    - two write ports targeting the same row.
//  - occupancy <= occupancy + writes - frees - flushed valid rows (exact, no wrap).
//    Full writes are dispatch's responsibility.
//  - Latency: a clear in cycle N makes the row ready (and issuable) in cycle N+1.
//  - rst mid-operation drops all entries in one cycle; in-flight ack ignored.
// STRUCTURE
//  - CORE_PKG: add typedef sched_row_idx_t (RIW bits) and constant SCHED_NUM_WR.
//  - Sub-module age_matrix_select: holds the age bits, takes ready_vector, outputs a one-hot oldest
//    and an encoded index.
//  - Top: dep/valid registers, clear-mask OR tree, per-row priority mux, occupancy counter.
// TESTING
//  1. Write row 3 deps=8'h05; clear col 0, then col 2 -> ready_vector[3]=1 one cycle after the 2nd clear;
//     changed_vector[3] pulses twice.
//  2. Same cycle: write row 1 deps=8'h10 and clear col 4 -> row 1 ready next cycle; issue_row=1.
//  3. Write rows 5,2 (ports 0,1), both deps=0 -> issue_row=5; ack -> issue_row=2; ack -> issue_valid=0.
//  4. Fill all 8 rows -> full=1, occupancy=8. Ack and write the same row in one cycle -> occupancy stays 8.
//     The new row is youngest.
//  5. flush_mask=8'hF0 with rows 4..7 valid -> occupancy drops by 4, those rows are never issued.
//     No changed pulse for them.
//  6. Assert rst with 6 rows valid -> next cycle occupancy=0, ready_vector=0, changed_vector=0.

Source files
------------

// File: rtl/dep_wakeup_age_matrix_pkg.sv
// Shared scheduler-bank constants and types for the dependency/age matrix.
// Provides bank geometry defaults and the row index type.
package dep_wakeup_age_matrix_pkg;

    localparam int SCHED_NUM_ROWS = 8;
    localparam int SCHED_NUM_COLS = 8;
    localparam int SCHED_NUM_WR   = 2;
    localparam int SCHED_NUM_CLR  = 2;

    typedef logic [$clog2(SCHED_NUM_ROWS)-1:0] sched_row_idx_t;

endpackage

// File: rtl/dep_wakeup_age_matrix_age_select.sv
// Age matrix and oldest-ready select for one scheduler bank.
// Ports: clk, rst, row_valid, wr_en, wr_row in; ready_vector in; oldest_oh, oldest_idx out.
module dep_wakeup_age_matrix_age_select
    import dep_wakeup_age_matrix_pkg::*;
#(
    parameter int NUM_ROWS = SCHED_NUM_ROWS,
    parameter int NUM_WR   = SCHED_NUM_WR,
    localparam int RIW     = $clog2(NUM_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_ROWS-1:0]   row_valid,
    input  logic [NUM_WR-1:0]     wr_en,
    input  logic [NUM_WR*RIW-1:0] wr_row,
    input  logic [NUM_ROWS-1:0]   ready_vector,
    output logic [NUM_ROWS-1:0]   oldest_oh,
    output logic [RIW-1:0]        oldest_idx
);

    // age_q[i][j] = 1 : row i is older than row j
    logic [NUM_ROWS-1:0][NUM_ROWS-1:0] age_q;
    logic [NUM_ROWS-1:0][NUM_ROWS-1:0] age_d;

    // Each written row becomes younger than everything already live and
    // than rows written by lower-numbered ports this cycle. Relations with
    // dead rows are left stale; they are rewritten when those rows return.
    always_comb begin
        logic [NUM_ROWS-1:0] prior;
        logic [RIW-1:0]      w;
        age_d = age_q;
        prior = row_valid;
        w     = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                w = wr_row[p*RIW +: RIW];
                for (int j = 0; j < NUM_ROWS; j++) begin
                    if (prior[j] && (RIW'(j) != w)) begin
                        age_d[j][w] = 1'b1;
                        age_d[w][j] = 1'b0;
                    end
                end
                prior[w] = 1'b1;
            end
        end
    end

    always_comb begin
        oldest_oh = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            oldest_oh[r] = ready_vector[r];
            for (int j = 0; j < NUM_ROWS; j++) begin
                if (ready_vector[j] && age_q[j][r]) begin
                    oldest_oh[r] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        oldest_idx = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (oldest_oh[r]) begin
                oldest_idx = RIW'(r);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/dep_wakeup_age_matrix.sv
// Dependency wakeup matrix with age-ordered issue select for one scheduler bank.
// Ports: dispatch writes (wr_*), wakeup clears (clr_*), flush, issue handshake, status.
module dep_wakeup_age_matrix
    import dep_wakeup_age_matrix_pkg::*;
#(
    parameter int NUM_ROWS = SCHED_NUM_ROWS,
    parameter int NUM_COLS = SCHED_NUM_COLS,
    parameter int NUM_WR   = SCHED_NUM_WR,
    parameter int NUM_CLR  = SCHED_NUM_CLR,
    localparam int RIW     = $clog2(NUM_ROWS),
    localparam int OCCW    = $clog2(NUM_ROWS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*RIW-1:0]       wr_row,
    input  logic [NUM_WR*NUM_COLS-1:0]  wr_deps,
    input  logic [NUM_CLR-1:0]          clr_en,
    input  logic [NUM_CLR*NUM_COLS-1:0] clr_cols,
    input  logic                        flush_en,
    input  logic [NUM_ROWS-1:0]         flush_mask,
    output logic                        issue_valid,
    output logic [RIW-1:0]              issue_row,
    input  logic                        issue_ack,
    output logic [NUM_ROWS-1:0]         ready_vector,
    output logic [NUM_ROWS-1:0]         changed_vector,
    output logic [OCCW-1:0]             occupancy,
    output logic                        full
);

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] dep_q;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] dep_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] wr_data;
    logic [NUM_ROWS-1:0]               valid_q;
    logic [NUM_ROWS-1:0]               valid_d;
    logic [NUM_ROWS-1:0]               chg_q;
    logic [NUM_ROWS-1:0]               chg_d;
    logic [NUM_ROWS-1:0]               wr_hit;
    logic [NUM_ROWS-1:0]               flush_vec;
    logic [NUM_ROWS-1:0]               free_vec;
    logic [NUM_ROWS-1:0]               oldest_oh;
    logic [NUM_COLS-1:0]               cm;
    logic [OCCW-1:0]                   occ_q;
    logic [OCCW-1:0]                   n_in;
    logic [OCCW-1:0]                   n_out;

    always_comb begin
        cm = '0;
        for (int k = 0; k < NUM_CLR; k++) begin
            if (clr_en[k]) begin
                cm = cm | clr_cols[k*NUM_COLS +: NUM_COLS];
            end
        end
    end

    always_comb begin
        wr_hit  = '0;
        wr_data = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (wr_en[p] && (wr_row[p*RIW +: RIW] == RIW'(r))) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = wr_deps[p*NUM_COLS +: NUM_COLS];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            ready_vector[r] = valid_q[r] && (dep_q[r] == '0);
        end
    end

    assign issue_valid = |ready_vector;
    assign free_vec    = (issue_ack && issue_valid) ? oldest_oh : '0;
    assign flush_vec   = flush_en ? flush_mask : '0;

    dep_wakeup_age_matrix_age_select #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_WR   (NUM_WR)
    ) u_age_select (
        .clk          (clk),
        .rst          (rst),
        .row_valid    (valid_q),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .ready_vector (ready_vector),
        .oldest_oh    (oldest_oh),
        .oldest_idx   (issue_row)
    );

    // Per-row priority: write > flush > free > clear. Writes apply the
    // same-cycle clear mask so a wakeup racing dispatch is not lost.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            dep_d[r]   = dep_q[r];
            valid_d[r] = valid_q[r];
            chg_d[r]   = 1'b0;
            if (wr_hit[r]) begin
                dep_d[r]   = wr_data[r] & ~cm;
                valid_d[r] = 1'b1;
            end else if (flush_vec[r] || free_vec[r]) begin
                dep_d[r]   = '0;
                valid_d[r] = 1'b0;
            end else if (valid_q[r]) begin
                dep_d[r] = dep_q[r] & ~cm;
                chg_d[r] = |(dep_q[r] & cm);
            end
        end
    end

    // A freed or flushed live row leaves even when rewritten; the rewrite
    // is counted separately as an arrival.
    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            n_in  = n_in + OCCW'(wr_hit[r]);
            n_out = n_out + OCCW'(valid_q[r] && (flush_vec[r] || free_vec[r]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dep_q   <= '0;
            valid_q <= '0;
            chg_q   <= '0;
            occ_q   <= '0;
        end else begin
            dep_q   <= dep_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
            occ_q   <= occ_q + n_in - n_out;
        end
    end

    assign changed_vector = chg_q;
    assign occupancy      = occ_q;
    assign full           = (occ_q == OCCW'(NUM_ROWS));

    always @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p]) begin
                    assert (!valid_q[wr_row[p*RIW +: RIW]] ||
                            flush_vec[wr_row[p*RIW +: RIW]] ||
                            free_vec[wr_row[p*RIW +: RIW]])
                    else $error("dispatch write to live row %0d", wr_row[p*RIW +: RIW]);
                end
                for (int q = p + 1; q < NUM_WR; q++) begin
                    assert (!(wr_en[p] && wr_en[q] &&
                              (wr_row[p*RIW +: RIW] == wr_row[q*RIW +: RIW])))
                    else $error("ports %0d and %0d write the same row", p, q);
                end
            end
        end
    end

endmodule

// File: tb/tb_dep_wakeup_age_matrix.sv
// Self-checking bench for dep_wakeup_age_matrix: directed scenarios then random traffic.
// Reference model tracks per-row deps, valid and a dispatch sequence number for age.
module tb_dep_wakeup_age_matrix;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_en;
    logic [5:0]  wr_row;
    logic [15:0] wr_deps;
    logic [1:0]  clr_en;
    logic [15:0] clr_cols;
    logic        flush_en;
    logic [7:0]  flush_mask;
    logic        issue_valid;
    logic [2:0]  issue_row;
    logic        issue_ack;
    logic [7:0]  ready_vector;
    logic [7:0]  changed_vector;
    logic [3:0]  occupancy;
    logic        full;

    int checks = 0;
    int errors = 0;

    bit [7:0] m_dep [8];
    bit       m_val [8];
    int       m_seq [8];
    bit [7:0] m_chg;
    int       m_next;

    dep_wakeup_age_matrix dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_row         (wr_row),
        .wr_deps        (wr_deps),
        .clr_en         (clr_en),
        .clr_cols       (clr_cols),
        .flush_en       (flush_en),
        .flush_mask     (flush_mask),
        .issue_valid    (issue_valid),
        .issue_row      (issue_row),
        .issue_ack      (issue_ack),
        .ready_vector   (ready_vector),
        .changed_vector (changed_vector),
        .occupancy      (occupancy),
        .full           (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            m_dep[r] = 0;
            m_val[r] = 0;
            m_seq[r] = 0;
        end
        m_chg  = 0;
        m_next = 1;
    endtask

    // Oldest ready row = smallest dispatch sequence number; -1 if none.
    function automatic int m_oldest();
        int best = -1;
        for (int r = 0; r < 8; r++) begin
            if (m_val[r] && m_dep[r] == 0) begin
                if (best < 0 || m_seq[r] < m_seq[best]) best = r;
            end
        end
        return best;
    endfunction

    function automatic bit [7:0] m_ready();
        bit [7:0] v = 0;
        for (int r = 0; r < 8; r++) v[r] = m_val[r] && (m_dep[r] == 0);
        return v;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < 8; r++) n += int'(m_val[r]);
        return n;
    endfunction

    task automatic check_all();
        int o;
        o = m_oldest();
        chk("ready_vector", 32'(ready_vector), 32'(m_ready()));
        chk("issue_valid", 32'(issue_valid), 32'(o >= 0));
        chk("issue_row", 32'(issue_row), 32'(o < 0 ? 0 : o));
        chk("changed_vector", 32'(changed_vector), 32'(m_chg));
        chk("occupancy", 32'(occupancy), 32'(m_count()));
        chk("full", 32'(full), 32'(m_count() == 8));
    endtask

    task automatic model_step();
        bit [7:0] cm;
        int fr;
        int o;
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        cm = 0;
        for (int k = 0; k < 2; k++) if (clr_en[k]) cm |= clr_cols[k*8 +: 8];
        o  = m_oldest();
        fr = (issue_ack && o >= 0) ? o : -1;
        for (int r = 0; r < 8; r++) begin
            if ((flush_en && flush_mask[r]) || r == fr) begin
                m_val[r] = 0;
                m_dep[r] = 0;
                m_chg[r] = 0;
            end else if (m_val[r]) begin
                m_chg[r] = (m_dep[r] & cm) != 0;
                m_dep[r] = m_dep[r] & ~cm;
            end else begin
                m_chg[r] = 0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                w        = int'(wr_row[p*3 +: 3]);
                m_dep[w] = wr_deps[p*8 +: 8] & ~cm;
                m_val[w] = 1;
                m_chg[w] = 0;
                m_seq[w] = m_next;
                m_next++;
            end
        end
    endtask

    task automatic idle();
        rst        = 1'b0;
        wr_en      = '0;
        wr_row     = '0;
        wr_deps    = '0;
        clr_en     = '0;
        clr_cols   = '0;
        flush_en   = 1'b0;
        flush_mask = '0;
        issue_ack  = 1'b0;
    endtask

    task automatic wr(input int p, input int row, input logic [7:0] deps);
        wr_en[p]          = 1'b1;
        wr_row[p*3 +: 3]  = 3'(row);
        wr_deps[p*8 +: 8] = deps;
    endtask

    task automatic clr(input int k, input logic [7:0] cols);
        clr_en[k]          = 1'b1;
        clr_cols[k*8 +: 8] = cols;
    endtask

    task automatic step();
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nw;
        int pick;
        int cand [$];
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_issue_row", 32'(issue_row), 32'd0);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);

        // 1: two clears wake row 3, changed pulses twice
        idle(); wr(0, 3, 8'h05); step();
        idle(); clr(0, 8'h01); step();
        chk("t1_chg1", 32'(changed_vector), 32'h08);
        chk("t1_notready", 32'(ready_vector), 32'h00);
        idle(); clr(1, 8'h04); step();
        chk("t1_ready", 32'(ready_vector), 32'h08);
        chk("t1_chg2", 32'(changed_vector), 32'h08);
        idle(); issue_ack = 1'b1; step();
        chk("t1_freed", 32'(occupancy), 32'd0);

        // 2: write and clear in the same cycle
        idle(); wr(0, 1, 8'h10); clr(1, 8'h10); step();
        chk("t2_ready", 32'(ready_vector), 32'h02);
        chk("t2_row", 32'(issue_row), 32'd1);
        chk("t2_nochg", 32'(changed_vector), 32'h00);
        idle(); issue_ack = 1'b1; step();

        // 3: port order sets age
        idle(); wr(0, 5, 8'h00); wr(1, 2, 8'h00); step();
        chk("t3_first", 32'(issue_row), 32'd5);
        idle(); issue_ack = 1'b1; step();
        chk("t3_second", 32'(issue_row), 32'd2);
        idle(); issue_ack = 1'b1; step();
        chk("t3_empty", 32'(issue_valid), 32'd0);

        // 4: fill, then ack + rewrite same row
        for (int i = 0; i < 4; i++) begin
            idle(); wr(0, 2*i, 8'h00); wr(1, 2*i+1, 8'h00); step();
        end
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_occ", 32'(occupancy), 32'd8);
        chk("t4_oldest", 32'(issue_row), 32'd0);
        idle(); issue_ack = 1'b1; wr(0, 0, 8'h00); step();
        chk("t4_occ_kept", 32'(occupancy), 32'd8);
        chk("t4_next", 32'(issue_row), 32'd1);
        for (int i = 0; i < 7; i++) begin
            idle(); issue_ack = 1'b1; step();
        end
        chk("t4_youngest", 32'(issue_row), 32'd0);
        idle(); issue_ack = 1'b1; step();
        chk("t4_drained", 32'(occupancy), 32'd0);

        // 5: flush upper rows while a clear hits every row
        idle(); wr(0, 4, 8'h01); wr(1, 5, 8'h01); step();
        idle(); wr(0, 6, 8'h01); wr(1, 7, 8'h01); step();
        idle(); wr(0, 0, 8'h01); wr(1, 1, 8'h01); step();
        idle(); flush_en = 1'b1; flush_mask = 8'hF0; clr(0, 8'h01); step();
        chk("t5_occ", 32'(occupancy), 32'd2);
        chk("t5_chg", 32'(changed_vector), 32'h03);
        chk("t5_ready", 32'(ready_vector), 32'h03);
        idle(); issue_ack = 1'b1; step();
        idle(); issue_ack = 1'b1; step();
        chk("t5_none", 32'(issue_valid), 32'd0);

        // 6: reset with six live rows and a pending clear/ack
        for (int i = 0; i < 3; i++) begin
            idle(); wr(0, 2*i, 8'h02); wr(1, 2*i+1, 8'h02); step();
        end
        chk("t6_occ6", 32'(occupancy), 32'd6);
        idle(); clr(0, 8'h02); issue_ack = 1'b1; rst = 1'b1; step();
        chk("t6_occ", 32'(occupancy), 32'd0);
        chk("t6_ready", 32'(ready_vector), 32'h00);
        chk("t6_chg", 32'(changed_vector), 32'h00);

        // Random traffic; writes only target rows the model holds empty
        for (int cyc = 0; cyc < 500; cyc++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            nw  = $urandom_range(0, 2);
            cand.delete();
            for (int r = 0; r < 8; r++) if (!m_val[r]) cand.push_back(r);
            for (int p = 0; p < nw; p++) begin
                if (cand.size() > 0) begin
                    pick = $urandom_range(0, cand.size() - 1);
                    wr(p, cand[pick], 8'($urandom & $urandom));
                    cand.delete(pick);
                end
            end
            clr_en     = 2'($urandom);
            clr_cols   = 16'($urandom & $urandom);
            flush_en   = ($urandom_range(0, 15) == 0);
            flush_mask = 8'($urandom);
            issue_ack  = 1'($urandom);
            step();
        end
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
